// File: rtl/maskmul_chk_pkg.sv
// Shared types and GF(2^2) arithmetic for the maskmul response checker.
// Field is GF(4) built on x^2 + x + 1.

package maskmul_chk_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFlush = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } chk_state_e;

    localparam logic [2:0] Gf4Poly = 3'b111;

    // Carry-less product, then fold x^2 back in using the reduction polynomial.
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] p;
        logic [2:0] r;
        p = {a[1] & b[1], (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
        r = p ^ ({3{p[2]}} & Gf4Poly);
        return r[1:0];
    endfunction

endpackage

// File: rtl/maskmul_gf4_ref.sv
// Combinational reference: unmask operands, multiply in GF(4), remask with mq.

module maskmul_gf4_ref
    import maskmul_chk_pkg::*;
(
    input  logic [1:0] am,
    input  logic [1:0] bm,
    input  logic [1:0] ma,
    input  logic [1:0] mb,
    input  logic [1:0] mq,
    output logic [1:0] exp
);

    assign exp = gf4_mul(am ^ ma, bm ^ mb) ^ mq;

endmodule

// File: rtl/maskmul_response_checker.sv
// Receive-side checker: recomputes the masked GF(4) product, aligns it to the fabric
// latency and compares it with qm_gfpga for a programmed number of cycles.

module maskmul_response_checker
    import maskmul_chk_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned NUM_CHECKS = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       am,
    input  logic [1:0]       bm,
    input  logic [1:0]       ma,
    input  logic [1:0]       mb,
    input  logic [1:0]       mq,
    input  logic [1:0]       qm_gfpga,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NUM_CHECKS - 1);

    logic [1:0] exp_now;
    logic [1:0] exp_d;
    logic       cmp_fail;

    maskmul_gf4_ref u_ref (
        .am  (am),
        .bm  (bm),
        .ma  (ma),
        .mb  (mb),
        .mq  (mq),
        .exp (exp_now)
    );

    // Expected value travels alongside the fabric pipeline regardless of FSM state.
    if (LATENCY == 0) begin : g_no_dly
        assign exp_d = exp_now;
    end else begin : g_dly
        logic [1:0] dly_q [LATENCY];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int unsigned i = 0; i < LATENCY; i++) begin
                    dly_q[i] <= 2'b00;
                end
            end else begin
                dly_q[0] <= exp_now;
                for (int unsigned i = 1; i < LATENCY; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign exp_d = dly_q[LATENCY-1];
    end

    assign cmp_fail = (qm_gfpga != exp_d);

    chk_state_e       state_q;
    logic [3:0]       flush_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             mismatch_q;
    logic [CNT_W-1:0] check_count_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] first_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            flush_q       <= 4'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            mismatch_q    <= 1'b0;
            check_count_q <= '0;
            err_count_q   <= '0;
            first_err_q   <= '1;
        end else begin
            mismatch_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        check_count_q <= '0;
                        err_count_q   <= '0;
                        first_err_q   <= '1;
                        flush_q       <= 4'(LATENCY);
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                        state_q       <= (LATENCY == 0) ? StCheck : StFlush;
                    end
                end
                StFlush: begin
                    flush_q <= flush_q - 4'd1;
                    if (flush_q == 4'd1) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    check_count_q <= check_count_q + 1'b1;
                    if (cmp_fail) begin
                        mismatch_q <= 1'b1;
                        if (err_count_q != '1) begin
                            err_count_q <= err_count_q + 1'b1;
                        end
                        if (err_count_q == '0) begin
                            first_err_q <= check_count_q;
                        end
                    end
                    if (check_count_q == LastIdx) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Final compare is folded in here since err_count_q has not caught up yet.
                        pass_q  <= (err_count_q == '0) && !cmp_fail;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign mismatch      = mismatch_q;
    assign check_count   = check_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_q;

endmodule

// File: doc/maskmul_response_checker.md
Name: maskmul_response_checker

Overview:
- Synthesizable receive-side checker for the maskmul formal flow; counterpart to the random stimulus driver.
- Watches the same shared inputs the driver applies (am, bm, ma, mb, mq) and recomputes the expected masked GF(2^2) product.
- Aligns that expected value to the fabric output latency and compares it against qm from the fabric.
- Accumulates check, error and first-error statistics, then reports pass/fail once a programmed number of checks has run.

Parameters:
- LATENCY, 1: clock cycles from stimulus applied to qm valid at the fabric output; 0..15 supported.
- NUM_CHECKS, 64: number of compare cycles per run; must be >= 1.
- CNT_W, 16: width of the check, error and first-error counters.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the clock rising edge.
- start  in  1  level; begins a run when sampled high in IDLE or DONE.
- am  in  2  masked operand a; bit0 = am_0_, bit1 = am_1_.
- bm  in  2  masked operand b.
- ma  in  2  mask of a.
- mb  in  2  mask of b.
- mq  in  2  output mask.
- qm_gfpga  in  2  fabric result under test.
- busy  out  1  high in FLUSH or CHECK.
- done  out  1  high in DONE.
- pass  out  1  done and err_count == 0.
- mismatch  out  1  one-cycle pulse on each failed compare.
- check_count  out  CNT_W  compares performed in the current run.
- err_count  out  CNT_W  failed compares; saturates at all-ones.
- first_err_idx  out  CNT_W  check_count value at the first failed compare; all-ones if there has been no error.

Behaviour:
- Reference model:
  - a = am^ma, b = bm^mb.
  - q = a*b in GF(4) with polynomial x^2+x+1: q0 = a0b0 ^ a1b1; q1 = a1b0 ^ a0b1 ^ a1b1.
  - exp = q^mq.
- Delay line:
  - LATENCY-deep shift register of exp, shifting every cycle in every state.
  - Output exp_d = exp delayed LATENCY cycles; LATENCY=0 means exp_d = exp combinationally.
- FSM states IDLE, FLUSH, CHECK, DONE.
  - IDLE: outputs quiet. start=1 -> clear counters, set first_err_idx to all-ones, flush counter = LATENCY, go to FLUSH; go straight to CHECK if LATENCY=0.
  - FLUSH: no compares; decrement the flush counter; go to CHECK in the cycle it reaches 0. Duration is exactly LATENCY cycles.
  - CHECK: compare every cycle.
    - mismatch = (qm_gfpga != exp_d).
    - check_count increments.
    - On mismatch, err_count increments (saturating). If err_count was 0, first_err_idx <= pre-increment check_count.
    - After compare number NUM_CHECKS, go to DONE.
    - start is ignored in CHECK.
  - DONE: hold all counters. start=1 restarts exactly as from IDLE.
- Reset values: state IDLE; busy/done/pass/mismatch 0; check_count 0; err_count 0; first_err_idx all-ones; delay line cleared to 0.
- Reset has priority over start and over any in-flight run. A reset in the middle of a run aborts it; no partial result is reported.
- mismatch is registered and asserted in the cycle after the failing compare. err_count updates in that same cycle.
- Simultaneous reset and start: reset wins; start must be re-sampled after reset deasserts.
- err_count saturation does not affect pass, which stays 0.
- check_count never exceeds NUM_CHECKS; it holds that value in DONE.

Decomposition:
- Package maskmul_chk_pkg:
  - state encoding (IDLE=0, FLUSH=1, CHECK=2, DONE=3)
  - gf4_mul function
  - constant for the GF(4) reduction polynomial
- Sub-module maskmul_gf4_ref: combinational unmask -> multiply -> remask, 10 inputs, 2-bit exp. Instantiated once.
- Delay line and FSM stay in the top module.

Test Plan:
- Known vector, LATENCY=1: am=01, ma=00, bm=10, mb=00, mq=00 -> exp=10. Drive qm_gfpga=10 one cycle later -> mismatch stays 0, err_count=0.
- Masked vector: am=01, ma=11 (a=2); bm=11, mb=01 (b=2); mq=10 -> q=11, exp=01. Drive qm=01 -> no error. Drive qm=11 -> mismatch pulse, err_count=1.
- NUM_CHECKS=8, all 8 results correct:
  - busy for LATENCY+8 cycles after start.
  - Then done=1, pass=1, check_count=8, first_err_idx=FFFF.
- Errors injected at compares 5 and 6 (0-based check_count):
  - err_count=2, first_err_idx=5, pass=0.
  - mismatch high exactly two cycles.
- Reset pulsed during CHECK at check_count=3 -> next cycle IDLE, counters 0, busy=0, done=0. A following start runs the full NUM_CHECKS.
- LATENCY=0 build: start -> CHECK immediately, same-cycle compare. Also verify start held high in DONE restarts a run, and start pulsed in CHECK is ignored.
